fp32_dot_accum: RTL and testbench
=================================

Name: fp32_dot_accum

Overview:
Sequential accumulator downstream of the fp32 product stage in the TensorCore datapath. It consumes a stream of fp32 terms, one per cycle, over a valid/ready handshake and sums each vector of up to LEN terms through one combinational fp32add instance into a registered accumulator. It then presents the fp32 dot-product result on an output valid/ready handshake. No overflow, NaN or Inf support, consistent with fp32add.

Parameters:
LEN, 4, maximum terms per vector; a vector ends at LEN terms or at in_last, whichever comes first; LEN >= 1.
CNT_W, $clog2(LEN+1), width of the term counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data and in_last are valid.
in_ready  output  1  block accepts a term this cycle.
in_data  input  32  fp32 term.
in_last  input  1  final term of the current vector.
out_valid  output  1  result is valid.
out_ready  input  1  consumer takes the result.
out_data  output  32  fp32 accumulated result.
out_count  output  CNT_W  number of terms summed into out_data.
busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, acc=32'h0, count=0, out_valid=0, in_ready=1, busy=0, out_data=0, out_count=0. A reset during ACCUM or DONE discards the partial or pending result, with no output beat.
- Accept means in_valid && in_ready on a rising edge.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=1. On accept: acc<=in_data loaded directly without the adder, count<=1. Go to DONE if in_last or LEN==1, else go to ACCUM.
- ACCUM: in_ready=1. On accept: acc<=add_res(acc,in_data), count<=count+1. Go to DONE if in_last or count+1==LEN. With no accept, hold.
- DONE: out_valid=1, out_data=acc, out_count=count, in_ready=out_ready.
  - Handshake with no simultaneous accept: go to IDLE.
  - Handshake with a simultaneous accept: the term starts the next vector, with the IDLE load semantics applied in the same cycle. No bubble.
  - out_ready=0: out_data and out_count stay stable; in_ready=0.
- add_res(a,b), evaluated in priority order:
  - b[30:0]==0: result is a (zero skip).
  - a[30:0]==0: result is b.
  - a[30:0]==b[30:0] and a[31]!=b[31]: result is 32'h0 (exact cancel; +0).
  - Otherwise: the fp32add output.
- Latency: result visible the cycle after the last term is accepted. Sustained throughput is one term per cycle with no idle cycle between vectors while out_ready=1.
- in_last with LEN already reached is redundant, with no extra effect. in_last on the first term gives a one-term vector with count=1.
- in_valid while in DONE with out_ready=0 is stalled, not dropped.
- The critical path is the combinational fp32add plus the guard mux into acc. It is not pipelined in this block.

Decomposition:
- Package fp32_pkg:
  - FP32_ZERO=32'h0.
  - Field localparams: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22.
  - State enum acc_state_t {IDLE, ACCUM, DONE}.
- One sub-module: the existing fp32add, instantiated once with A=acc and B=in_data.
- The guard logic stays in this block as a small combinational function.

Test Plan:
- LEN=4; terms 3F800000, 40000000, 40400000, 40800000 (1+2+3+4), last on the 4th -> one out beat, out_data=41200000 (10.0), out_count=4, one cycle after the 4th accept.
- in_last on the 2nd term: 3FC00000+40200000 (1.5+2.5) -> out_data=40800000 (4.0), out_count=2; in_last on the 1st term 40A00000 -> 40A00000, count=1.
- Cancel/zero: 40400000 then C0400000 -> 00000000; 00000000 then 40A00000 -> 40A00000.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 -> in_ready=0, out_data stable, no term lost. Then raise out_ready with in_valid=1 and term 3F800000 -> output handshake and new-vector accept in the same cycle; the next vector sums correctly.
- Reset mid-op: accept 2 terms, assert rst one cycle -> out_valid=0, busy=0, count=0; the following vector 1+1 (3F800000 x2, last) -> 40000000, count=2.
- Back-to-back: 3 vectors of 4 terms with out_ready=1 and in_valid=1 continuously -> 12 accepts in 12 cycles, 3 correct results, in_ready never low.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared fp32 field positions, constants and accumulator state encoding.
package fp32_pkg;

    localparam logic [31:0] FP32_ZERO = 32'h0;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/fp32add.sv
// Combinational fp32 adder: align, add/subtract, normalise, truncate.
// Subnormal inputs are flushed to zero, results that underflow become +0,
// no NaN/Inf/overflow handling.
module fp32add
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic        w_swap;
    logic [31:0] w_big;
    logic [31:0] w_sml;
    logic [7:0]  w_eb;
    logic [7:0]  w_es;
    logic [7:0]  w_d;
    logic [47:0] w_mb;
    logic [47:0] w_ms_raw;
    logic [47:0] w_ms;
    logic [48:0] w_sum;
    logic [5:0]  w_lead;
    logic [9:0]  w_exp_u;
    logic [48:0] w_norm;

    // Order operands by magnitude so the subtraction never goes negative
    // and the result sign is always the larger operand's sign.
    assign w_swap = b[EXP_MSB:0] > a[EXP_MSB:0];
    assign w_big  = w_swap ? b : a;
    assign w_sml  = w_swap ? a : b;
    assign w_eb   = w_big[EXP_MSB:EXP_LSB];
    assign w_es   = w_sml[EXP_MSB:EXP_LSB];
    assign w_d    = w_eb - w_es;

    // 24 extra low bits keep alignment exact for well-separated exponents.
    assign w_mb     = (w_eb != 8'd0) ? {1'b1, w_big[MAN_MSB:0], 24'b0} : 48'b0;
    assign w_ms_raw = (w_es != 8'd0) ? {1'b1, w_sml[MAN_MSB:0], 24'b0} : 48'b0;
    assign w_ms     = (w_d >= 8'd48) ? 48'b0 : (w_ms_raw >> w_d);

    assign w_sum = (w_big[SIGN_BIT] == w_sml[SIGN_BIT]) ? ({1'b0, w_mb} + {1'b0, w_ms})
                                                        : ({1'b0, w_mb} - {1'b0, w_ms});

    // Leading-one position of the raw sum; the highest set bit wins.
    always_comb begin
        w_lead = 6'd0;
        for (int i = 0; i < 49; i++) begin
            if (w_sum[i]) w_lead = 6'(i);
        end
    end

    // Hidden bit nominally sits at bit 47; shift so the leading one lands at 48.
    assign w_exp_u = {2'b0, w_eb} + {4'b0, w_lead};
    assign w_norm  = w_sum << (6'd48 - w_lead);

    // Pack, flushing zero sums and exponent underflow to +0.
    always_comb begin
        y = FP32_ZERO;
        if (w_sum != 49'b0 && w_exp_u > 10'd47) begin
            y = {w_big[SIGN_BIT], 8'(w_exp_u - 10'd47), w_norm[47:25]};
        end
    end

endmodule

// File: rtl/fp32_dot_accum.sv
// Streams fp32 terms into a registered accumulator, one per cycle, and
// emits the vector sum on an output handshake. A new vector may start in
// the same cycle the previous result is taken.
module fp32_dot_accum
    import fp32_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [31:0]      r_acc;
    logic [31:0]      w_acc_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [31:0]      w_add;
    logic             w_accept;
    logic             w_load;

    // Zero operands and exact cancellation bypass the adder so those
    // cases give a clean result (+0 on cancel) independent of its rounding.
    function automatic logic [31:0] guard_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] sum);
        if (b[EXP_MSB:0] == 31'd0)                          return a;
        else if (a[EXP_MSB:0] == 31'd0)                     return b;
        else if (a[EXP_MSB:0] == b[EXP_MSB:0] &&
                 a[SIGN_BIT] != b[SIGN_BIT])                return FP32_ZERO;
        else                                                return sum;
    endfunction

    fp32add u_add (
        .a (r_acc),
        .b (in_data),
        .y (w_add)
    );

    assign in_ready  = (r_state != DONE) || out_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_acc;
    assign out_count = r_count;
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = r_count + CNT_W'(1);

    // Next-state: accumulate in ACCUM, start a vector from IDLE or straight
    // out of DONE when the result handshake and a new term coincide.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_count;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_load = 1'b1;
            end
            ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = guard_add(r_acc, in_data, w_add);
                    w_cnt_nxt = w_cnt_inc;
                    if (in_last || w_cnt_inc == CNT_W'(LEN)) w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) w_load = 1'b1;
                    else          w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_load) begin
            w_acc_nxt   = in_data;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (in_last || LEN == 1) ? DONE : ACCUM;
        end
    end

    // State, accumulator and count registers; reset drops any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= FP32_ZERO;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fp32_dot_accum.sv
// Self-checking bench for fp32_dot_accum: constant vector table, directed
// backpressure/reset/back-to-back sequences and a randomised integer-valued
// stream checked against an integer-sum model.
module tb_fp32_dot_accum;

    localparam int LEN   = 4;
    localparam int CNT_W = $clog2(LEN + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = 32'h0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    fp32_dot_accum #(.LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    typedef struct {
        logic [3:0][31:0] t;
        int               n;
        logic             use_last;
        logic [31:0]      exp_d;
    } vec_t;

    exp_t q[$];
    int   part   = 0;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    // Integer to fp32 bit pattern (exact for |v| < 2^24).
    function automatic logic [31:0] i2f(input int v);
        int a;
        int m;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        m = 0;
        for (int i = 0; i < 31; i++) if (((a >> i) & 1) != 0) m = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + m);
        r[22:0]  = 23'((a << (23 - m)) & 32'h7FFFFF);
        return r;
    endfunction

    function automatic vec_t mk(input int n, input logic ul, input logic [31:0] e,
                                input logic [31:0] t0, input logic [31:0] t1,
                                input logic [31:0] t2, input logic [31:0] t3);
        vec_t v;
        v.n = n; v.use_last = ul; v.exp_d = e;
        v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
        return v;
    endfunction

    // One cycle: drive at negedge, check outputs against the scoreboard,
    // and predict the accept at the following posedge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic l,
                       input logic ordy, input logic [31:0] exp_d, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        #1;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || ordy));
        chk("busy", 32'(busy), 32'((part != 0) || (q.size() != 0)));
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 32'(out_valid), 32'h0);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_count", 32'(out_count), 32'(e.c));
            end
        end
        acc = v && in_ready;
        if (acc) begin
            part++;
            if (l || part == LEN) begin
                e.d = exp_d; e.c = part;
                q.push_back(e);
                part = 0;
            end
        end
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while (q.size() != 0 && n < 20) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, acc);
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'h0);
    endtask

    task automatic feed(input logic [31:0] d, input logic l, input logic [31:0] exp_d);
        logic acc = 1'b0;
        int   n = 0;
        while (!acc && n < 20) begin
            cyc(1'b1, d, l, 1'b1, exp_d, acc);
            n++;
        end
        chk("feed_timeout", 32'(acc), 32'h1);
    endtask

    vec_t tbl[6];

    initial begin
        logic        acc;
        logic [31:0] held;
        int          sum;
        int          val;
        int          nacc;
        logic        v, l, ordy;

        tbl[0] = mk(4, 1'b1, 32'h41200000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        tbl[1] = mk(2, 1'b1, 32'h40800000, 32'h3FC00000, 32'h40200000, 32'h0, 32'h0);
        tbl[2] = mk(1, 1'b1, 32'h40A00000, 32'h40A00000, 32'h0, 32'h0, 32'h0);
        tbl[3] = mk(2, 1'b1, 32'h00000000, 32'h40400000, 32'hC0400000, 32'h0, 32'h0);
        tbl[4] = mk(2, 1'b1, 32'h40A00000, 32'h00000000, 32'h40A00000, 32'h0, 32'h0);
        tbl[5] = mk(4, 1'b0, 32'h40800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_count", 32'(out_count), 32'h0);

        // Table of constant vectors, streamed back to back
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                feed(tbl[i].t[k], tbl[i].use_last && (k == tbl[i].n - 1), tbl[i].exp_d);
            end
        end
        drain();

        // Backpressure: result 3.0 held while a term waits, then handshake+accept
        feed(32'h3F800000, 1'b0, 32'h0);
        feed(32'h40000000, 1'b1, 32'h40400000);
        cyc(1'b1, 32'h3F800000, 1'b0, 1'b0, 32'h0, acc);
        held = out_data;
        chk("bp_data", held, 32'h40400000);
        chk("bp_no_accept", 32'(acc), 32'h0);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 32'h3F800000, 1'b0, 1'b0, 32'h0, acc);
            chk("bp_stable", out_data, held);
            chk("bp_no_accept", 32'(acc), 32'h0);
        end
        cyc(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h0, acc);
        chk("bp_release_accept", 32'(acc), 32'h1);
        feed(32'h40000000, 1'b1, 32'h40400000);
        drain();

        // Reset mid-vector discards the partial sum
        feed(32'h40400000, 1'b0, 32'h0);
        feed(32'h40400000, 1'b0, 32'h0);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        q.delete(); part = 0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_count", 32'(out_count), 32'h0);
        feed(32'h3F800000, 1'b0, 32'h0);
        feed(32'h3F800000, 1'b1, 32'h40000000);
        drain();

        // Back-to-back: 3 vectors x 4 terms, 12 accepts in 12 cycles
        sum = 0; nacc = 0;
        for (int k = 0; k < 12; k++) begin
            val = int'($urandom_range(200)) - 100;
            cyc(1'b1, i2f(val), (k % 4) == 3, 1'b1, i2f(sum + val), acc);
            if (acc) begin
                nacc++;
                sum = (part == 0) ? 0 : sum + val;
            end
        end
        chk("b2b_accepts", 32'(nacc), 32'd12);
        drain();

        // Randomised stream with gaps, early last and backpressure
        sum = 0;
        for (int k = 0; k < 400; k++) begin
            v    = ($urandom_range(3) != 0);
            l    = ($urandom_range(3) == 0);
            ordy = ($urandom_range(3) != 0);
            val  = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(200)) - 100;
            cyc(v, i2f(val), l, ordy, i2f(sum + val), acc);
            if (acc) sum = (part == 0) ? 0 : sum + val;
        end
        // Close any open vector, then take the final result
        if (part != 0) feed(32'h0, 1'b1, i2f(sum));
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
